morty_wb_queue: RTL and testbench

Write-back queue for the Morty core: the writer side of the 32x32 register file. It accepts completed results from the ALU and the load/store unit over valid/ready handshakes, buffers them in a small in-order FIFO, and drains one entry per cycle into the register file write port. It also answers two combinational bypass lookups, so operand fetch sees queued but not-yet-written values.

---
 rtl/morty_pkg.sv | 10 +
 rtl/morty_wb_fifo.sv | 58 +++++
 rtl/morty_wb_queue.sv | 86 ++++++++
 tb/tb_morty_wb_queue.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/morty_pkg.sv
// Shared Morty core types: register-file geometry and the write-back entry layout.
package morty_pkg;
   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_entry_t;
endpackage

// File: rtl/morty_wb_fifo.sv
// Circular buffer of write-back entries with a flat entry/valid view for bypass compares.
module morty_wb_fifo
   import morty_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push,
   input  wb_entry_t               push_entry,
   input  logic                    pop,
   output wb_entry_t               head,
   output logic [CW-1:0]           count,
   output logic [PW-1:0]           head_ptr,
   output wb_entry_t [DEPTH-1:0]   entries,
   output logic [DEPTH-1:0]        valid
);
   wb_entry_t [DEPTH-1:0] mem;
   logic [DEPTH-1:0]      vld;
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (pop) begin
            vld[rd_ptr] <= 1'b0;
            rd_ptr      <= rd_ptr + PW'(1);
         end
         if (push) begin
            vld[wr_ptr] <= 1'b1;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Payload carries no reset; valid bits alone define occupancy.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_entry;
   end

   assign head     = mem[rd_ptr];
   assign count    = cnt;
   assign head_ptr = rd_ptr;
   assign entries  = mem;
   assign valid    = vld;
endmodule

// File: rtl/morty_wb_queue.sv
// Write-back queue: LSU/ALU arbitration, rd==0 filtering, drain to the register file and bypass lookup.
module morty_wb_queue
   import morty_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int XLEN  = morty_pkg::XLEN,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_valid,
   input  logic [4:0]        alu_rd,
   input  logic [XLEN-1:0]   alu_data,
   output logic              alu_ready,
   input  logic              lsu_valid,
   input  logic [4:0]        lsu_rd,
   input  logic [XLEN-1:0]   lsu_data,
   output logic              lsu_ready,
   output logic              we,
   output logic [4:0]        waddr_rd,
   output logic [XLEN-1:0]   wdata_rd,
   input  logic [4:0]        byp_addr_rs1,
   input  logic [4:0]        byp_addr_rs2,
   output logic              byp_hit_rs1,
   output logic              byp_hit_rs2,
   output logic [XLEN-1:0]   byp_data_rs1,
   output logic [XLEN-1:0]   byp_data_rs2,
   output logic [CW-1:0]     pending
);
   wb_entry_t             head, in_entry;
   wb_entry_t [DEPTH-1:0] entries;
   logic [DEPTH-1:0]      valid;
   logic [PW-1:0]         head_ptr;
   logic [CW-1:0]         count;
   logic                  has_room, accept, push, pop;
   logic [XLEN:0]         byp1, byp2;

   // Room is judged on the registered count only, so a full queue stays closed while draining.
   assign has_room  = count < CW'(DEPTH);
   assign lsu_ready = has_room;
   assign alu_ready = has_room && !lsu_valid;

   assign in_entry = lsu_valid ? '{rd: lsu_rd, data: lsu_data} : '{rd: alu_rd, data: alu_data};
   assign accept   = (lsu_valid && lsu_ready) || (alu_valid && alu_ready);
   assign push     = accept && (in_entry.rd != '0);
   assign pop      = count != '0;

   morty_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_entry (in_entry),
      .pop        (pop),
      .head       (head),
      .count      (count),
      .head_ptr   (head_ptr),
      .entries    (entries),
      .valid      (valid)
   );

   assign we       = pop;
   assign waddr_rd = pop ? head.rd : '0;
   assign wdata_rd = pop ? head.data : '0;
   assign pending  = count;

   // Walk oldest to youngest so the last match (closest to tail) wins; result is {hit, data}.
   function automatic logic [XLEN:0] lookup(input logic [4:0] a,
                                            input wb_entry_t [DEPTH-1:0] ent,
                                            input logic [DEPTH-1:0] v,
                                            input logic [PW-1:0] hp);
      logic [PW-1:0] idx;
      lookup = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = hp + PW'(i);
         if (a != '0 && v[idx] && ent[idx].rd == a) lookup = {1'b1, ent[idx].data};
      end
   endfunction

   assign byp1         = lookup(byp_addr_rs1, entries, valid, head_ptr);
   assign byp2         = lookup(byp_addr_rs2, entries, valid, head_ptr);
   assign byp_hit_rs1  = byp1[XLEN];
   assign byp_data_rs1 = byp1[XLEN-1:0];
   assign byp_hit_rs2  = byp2[XLEN];
   assign byp_data_rs2 = byp2[XLEN-1:0];
endmodule

// File: tb/tb_morty_wb_queue.sv
// Bench for morty_wb_queue: reference queue scoreboard plus a vector table with fixed expectations.
module tb_morty_wb_queue;
   localparam int DEPTH = 4;
   localparam int XLEN  = 32;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic            clk = 1'b0, rst_n = 1'b0;
   logic            alu_valid = 0, lsu_valid = 0;
   logic [4:0]      alu_rd = 0, lsu_rd = 0, byp_addr_rs1 = 0, byp_addr_rs2 = 0;
   logic [XLEN-1:0] alu_data = 0, lsu_data = 0;
   logic            alu_ready, lsu_ready, we, byp_hit_rs1, byp_hit_rs2;
   logic [4:0]      waddr_rd;
   logic [XLEN-1:0] wdata_rd, byp_data_rs1, byp_data_rs2;
   logic [CW-1:0]   pending;

   morty_wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
      .we(we), .waddr_rd(waddr_rd), .wdata_rd(wdata_rd),
      .byp_addr_rs1(byp_addr_rs1), .byp_addr_rs2(byp_addr_rs2),
      .byp_hit_rs1(byp_hit_rs1), .byp_hit_rs2(byp_hit_rs2),
      .byp_data_rs1(byp_data_rs1), .byp_data_rs2(byp_data_rs2),
      .pending(pending)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic lv; logic [4:0] lrd; logic [31:0] ld;
      logic av; logic [4:0] ard; logic [31:0] ad;
      logic [4:0] b1, b2;
      logic e_ar, e_lr, e_we; logic [4:0] e_wa; int e_pend;
   } vec_t;

   typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;

   ent_t sb[$];
   int   n_tests = 0, n_fail = 0;
   vec_t tbl[10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                               input logic av, input logic [4:0] ard, input logic [31:0] ad,
                               input logic [4:0] b1, input logic [4:0] b2,
                               input logic e_ar, input logic e_lr, input logic e_we,
                               input logic [4:0] e_wa, input int e_pend);
      vec_t v;
      v.lv = lv; v.lrd = lrd; v.ld = ld; v.av = av; v.ard = ard; v.ad = ad;
      v.b1 = b1; v.b2 = b2; v.e_ar = e_ar; v.e_lr = e_lr; v.e_we = e_we;
      v.e_wa = e_wa; v.e_pend = e_pend;
      return v;
   endfunction

   // Expected bypass from the reference queue: youngest match wins.
   task automatic byp_check(input string name, input logic [4:0] a, input logic hit, input logic [31:0] data);
      logic eh = 1'b0; logic [31:0] ed = '0;
      if (a != 0)
         for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].rd == a) begin eh = 1'b1; ed = sb[i].data; break; end
      check({name, "_hit"}, 64'(hit), 64'(eh));
      check({name, "_data"}, 64'(data), 64'(ed));
   endtask

   // Called just after a falling edge; ends at the next falling edge.
   task automatic cycle(input vec_t v, input bit use_tbl);
      logic full, e_lr, e_ar;
      lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ld;
      alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
      byp_addr_rs1 = v.b1; byp_addr_rs2 = v.b2;
      #1;
      full = sb.size() >= DEPTH;
      e_lr = !full;
      e_ar = !full && !v.lv;
      check("lsu_ready", 64'(lsu_ready), 64'(e_lr));
      check("alu_ready", 64'(alu_ready), 64'(e_ar));
      check("pending", 64'(pending), 64'(sb.size()));
      check("we", 64'(we), 64'(sb.size() > 0));
      check("waddr", 64'(waddr_rd), sb.size() > 0 ? 64'(sb[0].rd) : 64'd0);
      check("wdata", 64'(wdata_rd), sb.size() > 0 ? 64'(sb[0].data) : 64'd0);
      byp_check("rs1", v.b1, byp_hit_rs1, byp_data_rs1);
      byp_check("rs2", v.b2, byp_hit_rs2, byp_data_rs2);
      if (use_tbl) begin
         check("tbl_alu_ready", 64'(alu_ready), 64'(v.e_ar));
         check("tbl_lsu_ready", 64'(lsu_ready), 64'(v.e_lr));
         check("tbl_we", 64'(we), 64'(v.e_we));
         check("tbl_waddr", 64'(waddr_rd), 64'(v.e_wa));
         check("tbl_pending", 64'(pending), 64'(v.e_pend));
      end
      if (sb.size() > 0) void'(sb.pop_front());
      if (v.lv && e_lr) begin
         if (v.lrd != 0) sb.push_back('{rd: v.lrd, data: v.ld});
      end else if (v.av && e_ar) begin
         if (v.ard != 0) sb.push_back('{rd: v.ard, data: v.ad});
      end
      @(negedge clk);
   endtask

   vec_t idle;

   initial begin
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      //           lv lrd ld     av ard ad            b1 b2 ar lr we wa pend
      tbl[0] = mk(0, 0, 0,      1, 5, 32'hDEADBEEF, 0, 0, 1, 1, 0, 0, 0);
      tbl[1] = mk(0, 0, 0,      0, 0, 0,            5, 0, 1, 1, 1, 5, 1);
      tbl[2] = mk(0, 0, 0,      0, 0, 0,            5, 0, 1, 1, 0, 0, 0);
      tbl[3] = mk(1, 4, 32'h22, 1, 3, 32'h11,       4, 3, 0, 1, 0, 0, 0);
      tbl[4] = mk(0, 0, 0,      1, 3, 32'h11,       4, 3, 1, 1, 1, 4, 1);
      tbl[5] = mk(0, 0, 0,      0, 0, 0,            4, 3, 1, 1, 1, 3, 1);
      tbl[6] = mk(0, 0, 0,      0, 0, 0,            3, 0, 1, 1, 0, 0, 0);
      tbl[7] = mk(0, 0, 0,      1, 0, 32'hFFFF,     0, 0, 1, 1, 0, 0, 0);
      tbl[8] = mk(0, 0, 0,      0, 0, 0,            0, 0, 1, 1, 0, 0, 0);
      tbl[9] = mk(0, 0, 0,      0, 0, 0,            0, 0, 1, 1, 0, 0, 0);

      // Reset state, including the combinational lsu_valid gate on alu_ready.
      @(negedge clk);
      check("rst_we", 64'(we), 0);
      check("rst_pending", 64'(pending), 0);
      check("rst_alu_ready", 64'(alu_ready), 1);
      check("rst_lsu_ready", 64'(lsu_ready), 1);
      lsu_valid = 1; #1;
      check("rst_alu_ready_lsu", 64'(alu_ready), 0);
      lsu_valid = 0;
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) cycle(tbl[i], 1'b1);

      // Back-to-back LSU stream across several pointer wraps.
      for (int i = 0; i < 3 * DEPTH + 2; i++)
         cycle(mk(1, 5'(1 + i % 31), $urandom, 0, 0, 0, 5'(1 + i % 31), 0, 0, 0, 0, 0, 0), 1'b0);
      cycle(idle, 1'b0);
      cycle(idle, 1'b0);

      // Same-rd writes: bypass follows the youngest queued value; rs2 = x0 never hits.
      cycle(mk(1, 7, 32'h1, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0), 1'b0);
      cycle(mk(1, 7, 32'h2, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0), 1'b0);
      cycle(mk(0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0), 1'b0);
      cycle(mk(0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0), 1'b0);

      // Asynchronous reset with an entry at the head.
      cycle(mk(1, 9, 32'hAB, 0, 0, 0, 9, 9, 0, 0, 0, 0, 0), 1'b0);
      lsu_valid = 0; byp_addr_rs1 = 9; byp_addr_rs2 = 9;
      #1;
      check("pre_rst_we", 64'(we), 1);
      check("pre_rst_hit", 64'(byp_hit_rs1), 1);
      rst_n = 1'b0;
      #1;
      check("async_we", 64'(we), 0);
      check("async_waddr", 64'(waddr_rd), 0);
      check("async_pending", 64'(pending), 0);
      check("async_hit1", 64'(byp_hit_rs1), 0);
      check("async_hit2", 64'(byp_hit_rs2), 0);
      check("async_data1", 64'(byp_data_rs1), 0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) cycle(mk(0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0, 0, 0), 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running, want finished");
      $fatal(1);
   end
endmodule
